// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a single-accumulator multicycle datapath. One state per
//   cycle; memory states stall on mem_ready. Also counts completed fetches.
//
// Ports
//   clk          single clock, all state on rising edge
//   rst          synchronous reset, active low; also gates all write/enables
//   opcode[2:0]  ir[15:13]   000 LOAD, 001 STORE, 010 JUMP, 011 BRANZ,
//                            100 ALU, 101/110/111 reserved (NOP)
//   func[2:0]    ir[2:0]     ALU function for opcode 100 (111 = NOP)
//   zero         ALU zero flag, used by BRANZ
//   mem_ready    memory access complete
//   iord, mem_read, mem_write, ir_write, acc_write, mem_to_acc,
//   alu_src_a, pc_src, pc_en    datapath controls
//   alu_src_b[1:0]   00 MDR, 01 const 1, 10 IR address
//   alu_opc[2:0]     000 add .. 110 pass B
//   state[2:0]       current state (debug)
//   instr_count[N-1:0]  completed fetches, wraps modulo 2^N
module multicycle_controller #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   opcode,
  input  logic [2:0]   func,
  input  logic         zero,
  input  logic         mem_ready,
  output logic         iord,
  output logic         mem_read,
  output logic         mem_write,
  output logic         ir_write,
  output logic         acc_write,
  output logic         mem_to_acc,
  output logic         alu_src_a,
  output logic         pc_src,
  output logic         pc_en,
  output logic [1:0]   alu_src_b,
  output logic [2:0]   alu_opc,
  output logic [2:0]   state,
  output logic [N-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    MEM_RD  = 3'd2,
    LOAD_WB = 3'd3,
    MEM_WR  = 3'd4,
    JUMP    = 3'd5,
    BRANCH  = 3'd6,
    ALU_EX  = 3'd7
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_JUMP  = 3'b010;
  localparam logic [2:0] OP_BRANZ = 3'b011;
  localparam logic [2:0] OP_ALU   = 3'b100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_PASSA = 3'b101;
  localparam logic [2:0] FN_NOP    = 3'b111;

  localparam logic [1:0] SRCB_MDR  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t cur, nxt;
  logic [N-1:0] cnt;

  // raw write/enables before the reset gate
  logic mem_read_r, mem_write_r, ir_write_r, acc_write_r, pc_en_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur <= FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      if (cur == FETCH && mem_ready) cnt <= cnt + CNT_ONE;
    end
  end

  always_comb begin
    nxt         = cur;
    iord        = 1'b0;
    mem_read_r  = 1'b0;
    mem_write_r = 1'b0;
    ir_write_r  = 1'b0;
    acc_write_r = 1'b0;
    pc_en_r     = 1'b0;
    mem_to_acc  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_MDR;
    alu_opc     = ALU_ADD;
    pc_src      = 1'b0;
    case (cur)
      FETCH: begin
        // PC + 1 computed in the ALU while the instruction is read
        mem_read_r = 1'b1;
        alu_src_b  = SRCB_ONE;
        if (mem_ready) begin
          ir_write_r = 1'b1;
          pc_en_r    = 1'b1;
          nxt        = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_ALU: nxt = MEM_RD;
          OP_STORE:        nxt = MEM_WR;
          OP_JUMP:         nxt = JUMP;
          OP_BRANZ:        nxt = BRANCH;
          default:         nxt = FETCH;   // reserved opcodes act as NOP
        endcase
      end
      MEM_RD: begin
        iord       = 1'b1;
        mem_read_r = 1'b1;
        if (mem_ready) begin
          if (opcode == OP_LOAD)     nxt = LOAD_WB;
          else if (opcode == OP_ALU) nxt = ALU_EX;
          else                       nxt = FETCH;
        end
      end
      LOAD_WB: begin
        acc_write_r = 1'b1;
        mem_to_acc  = 1'b1;
        nxt         = FETCH;
      end
      MEM_WR: begin
        iord        = 1'b1;
        mem_write_r = 1'b1;
        if (mem_ready) nxt = FETCH;
      end
      JUMP: begin
        pc_en_r = 1'b1;
        pc_src  = 1'b1;
        nxt     = FETCH;
      end
      BRANCH: begin
        // ACC passes through the ALU; the PC loads only when the flag is set
        alu_src_a = 1'b1;
        alu_opc   = ALU_PASSA;
        pc_src    = 1'b1;
        pc_en_r   = zero;
        nxt       = FETCH;
      end
      ALU_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_MDR;
        if (func == FN_NOP) begin
          alu_opc     = ALU_ADD;
          acc_write_r = 1'b0;
        end else begin
          alu_opc     = func;
          acc_write_r = 1'b1;
        end
        nxt = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  // reset suppresses every side effect in the same cycle
  assign mem_read    = mem_read_r  & rst;
  assign mem_write   = mem_write_r & rst;
  assign ir_write    = ir_write_r  & rst;
  assign acc_write   = acc_write_r & rst;
  assign pc_en       = pc_en_r     & rst;
  assign state       = cur;
  assign instr_count = cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode, func;
  logic       zero, mem_ready;
  logic       iord, mem_read, mem_write, ir_write, acc_write, mem_to_acc;
  logic       alu_src_a, pc_src, pc_en;
  logic [1:0] alu_src_b;
  logic [2:0] alu_opc, state;
  logic [3:0] instr_count;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  multicycle_controller #(.N(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .acc_write(acc_write),
    .mem_to_acc(mem_to_acc), .alu_src_a(alu_src_a), .pc_src(pc_src),
    .pc_en(pc_en), .alu_src_b(alu_src_b), .alu_opc(alu_opc),
    .state(state), .instr_count(instr_count)
  );

  // ctl = {iord, mem_read, mem_write, ir_write, acc_write, mem_to_acc, pc_en, pc_src}
  // sel = {alu_src_a, alu_src_b}
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] ctl;
    logic [2:0] sel;
    logic [2:0] opc;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    logic       r;
    logic [2:0] op;
    logic [2:0] fn;
    logic       z;
    logic       rdy;
    exp_t       e;
  } step_t;

  localparam logic [7:0] C_F1   = 8'b0101_0010;
  localparam logic [7:0] C_F0   = 8'b0100_0000;
  localparam logic [7:0] C_00   = 8'b0000_0000;
  localparam logic [7:0] C_RD   = 8'b1100_0000;
  localparam logic [7:0] C_LW   = 8'b0000_1100;
  localparam logic [7:0] C_WR   = 8'b1010_0000;
  localparam logic [7:0] C_WRR  = 8'b1000_0000;
  localparam logic [7:0] C_JP   = 8'b0000_0011;
  localparam logic [7:0] C_BR0  = 8'b0000_0001;
  localparam logic [7:0] C_AX   = 8'b0000_1000;
  localparam logic [2:0] S_F = 3'b001, S_0 = 3'b000, S_A = 3'b100;

  exp_t sb[$];

  function automatic exp_t mk(logic [2:0] st, logic [7:0] c, logic [2:0] sl,
                              logic [2:0] o, logic [3:0] n);
    exp_t x;
    x = {st, c, sl, o, n};
    return x;
  endfunction

  function automatic step_t sp(logic r, logic [2:0] op, logic [2:0] fn,
                               logic z, logic rdy, exp_t e);
    step_t x;
    x.r = r; x.op = op; x.fn = fn; x.z = z; x.rdy = rdy; x.e = e;
    return x;
  endfunction

  function automatic exp_t obs();
    exp_t x;
    x = {state, iord, mem_read, mem_write, ir_write, acc_write, mem_to_acc,
         pc_en, pc_src, alu_src_a, alu_src_b, alu_opc, instr_count};
    return x;
  endfunction

  task automatic drive(input step_t x);
    @(negedge clk);
    rst = x.r; opcode = x.op; func = x.fn; zero = x.z; mem_ready = x.rdy;
    #1;
  endtask

  // mem_read and mem_write are never both high
  always @(negedge clk) begin
    if (armed) begin
      #2;
      checks++;
      if (mem_read && mem_write) begin
        errors++;
        $display("FAIL rw_exclusive t=%0t got mem_read=1 mem_write=1 need not both", $time);
      end
    end
  end

  task automatic test_reset();
    step_t s[$]; exp_t e, o;
    s.push_back(sp(0, 3'b000, 0, 0, 1, mk(0, C_00, S_F, 3'b000, 0)));
    s.push_back(sp(1, 3'b000, 0, 0, 0, mk(0, C_F0, S_F, 3'b000, 0)));
    s.push_back(sp(1, 3'b000, 0, 0, 0, mk(0, C_F0, S_F, 3'b000, 0)));
    foreach (s[i]) begin
      sb.push_back(s[i].e); drive(s[i]);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset step%0d got st=%0d ctl=%b sel=%b opc=%b cnt=%0d need st=%0d ctl=%b sel=%b opc=%b cnt=%0d",
                 i, o.st, o.ctl, o.sel, o.opc, o.cnt, e.st, e.ctl, e.sel, e.opc, e.cnt);
      end
    end
  endtask

  task automatic test_load();
    step_t s[$]; exp_t e, o;
    s.push_back(sp(1, 3'b000, 0, 0, 1, mk(0, C_F1, S_F, 3'b000, 0)));
    s.push_back(sp(1, 3'b000, 0, 0, 1, mk(1, C_00, S_0, 3'b000, 1)));
    s.push_back(sp(1, 3'b000, 0, 0, 1, mk(2, C_RD, S_0, 3'b000, 1)));
    s.push_back(sp(1, 3'b000, 0, 0, 1, mk(3, C_LW, S_0, 3'b000, 1)));
    s.push_back(sp(1, 3'b000, 0, 0, 0, mk(0, C_F0, S_F, 3'b000, 1)));
    foreach (s[i]) begin
      sb.push_back(s[i].e); drive(s[i]);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load step%0d got st=%0d ctl=%b sel=%b opc=%b cnt=%0d need st=%0d ctl=%b sel=%b opc=%b cnt=%0d",
                 i, o.st, o.ctl, o.sel, o.opc, o.cnt, e.st, e.ctl, e.sel, e.opc, e.cnt);
      end
    end
  endtask

  task automatic test_alu_wait();
    step_t s[$]; exp_t e, o;
    s.push_back(sp(1, 3'b100, 3'b001, 0, 1, mk(0, C_F1, S_F, 3'b000, 1)));
    s.push_back(sp(1, 3'b100, 3'b001, 0, 1, mk(1, C_00, S_0, 3'b000, 2)));
    s.push_back(sp(1, 3'b100, 3'b001, 0, 0, mk(2, C_RD, S_0, 3'b000, 2)));
    s.push_back(sp(1, 3'b100, 3'b001, 0, 0, mk(2, C_RD, S_0, 3'b000, 2)));
    s.push_back(sp(1, 3'b100, 3'b001, 0, 1, mk(2, C_RD, S_0, 3'b000, 2)));
    s.push_back(sp(1, 3'b100, 3'b001, 0, 1, mk(7, C_AX, S_A, 3'b001, 2)));
    s.push_back(sp(1, 3'b100, 3'b001, 0, 0, mk(0, C_F0, S_F, 3'b000, 2)));
    foreach (s[i]) begin
      sb.push_back(s[i].e); drive(s[i]);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL alu_wait step%0d got st=%0d ctl=%b sel=%b opc=%b cnt=%0d need st=%0d ctl=%b sel=%b opc=%b cnt=%0d",
                 i, o.st, o.ctl, o.sel, o.opc, o.cnt, e.st, e.ctl, e.sel, e.opc, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    step_t s[$]; exp_t e, o;
    s.push_back(sp(1, 3'b011, 0, 1, 1, mk(0, C_F1, S_F, 3'b000, 2)));
    s.push_back(sp(1, 3'b011, 0, 1, 1, mk(1, C_00, S_0, 3'b000, 3)));
    s.push_back(sp(1, 3'b011, 0, 1, 1, mk(6, C_JP, S_A, 3'b101, 3)));
    s.push_back(sp(1, 3'b011, 0, 0, 1, mk(0, C_F1, S_F, 3'b000, 3)));
    s.push_back(sp(1, 3'b011, 0, 0, 1, mk(1, C_00, S_0, 3'b000, 4)));
    s.push_back(sp(1, 3'b011, 0, 0, 1, mk(6, C_BR0, S_A, 3'b101, 4)));
    s.push_back(sp(1, 3'b011, 0, 0, 0, mk(0, C_F0, S_F, 3'b000, 4)));
    foreach (s[i]) begin
      sb.push_back(s[i].e); drive(s[i]);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL branch step%0d got st=%0d ctl=%b sel=%b opc=%b cnt=%0d need st=%0d ctl=%b sel=%b opc=%b cnt=%0d",
                 i, o.st, o.ctl, o.sel, o.opc, o.cnt, e.st, e.ctl, e.sel, e.opc, e.cnt);
      end
    end
  endtask

  task automatic test_store_reset();
    step_t s[$]; exp_t e, o;
    // plain store, 3 cycles
    s.push_back(sp(1, 3'b001, 0, 0, 1, mk(0, C_F1, S_F, 3'b000, 4)));
    s.push_back(sp(1, 3'b001, 0, 0, 1, mk(1, C_00, S_0, 3'b000, 5)));
    s.push_back(sp(1, 3'b001, 0, 0, 1, mk(4, C_WR, S_0, 3'b000, 5)));
    // store aborted by reset while waiting
    s.push_back(sp(1, 3'b001, 0, 0, 1, mk(0, C_F1, S_F, 3'b000, 5)));
    s.push_back(sp(1, 3'b001, 0, 0, 1, mk(1, C_00, S_0, 3'b000, 6)));
    s.push_back(sp(1, 3'b001, 0, 0, 0, mk(4, C_WR, S_0, 3'b000, 6)));
    s.push_back(sp(0, 3'b001, 0, 0, 0, mk(4, C_WRR, S_0, 3'b000, 6)));
    s.push_back(sp(1, 3'b001, 0, 0, 0, mk(0, C_F0, S_F, 3'b000, 0)));
    foreach (s[i]) begin
      sb.push_back(s[i].e); drive(s[i]);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL store_reset step%0d got st=%0d ctl=%b sel=%b opc=%b cnt=%0d need st=%0d ctl=%b sel=%b opc=%b cnt=%0d",
                 i, o.st, o.ctl, o.sel, o.opc, o.cnt, e.st, e.ctl, e.sel, e.opc, e.cnt);
      end
    end
  endtask

  task automatic test_nop();
    step_t s[$]; exp_t e, o;
    s.push_back(sp(1, 3'b110, 0, 1, 1, mk(0, C_F1, S_F, 3'b000, 0)));
    s.push_back(sp(1, 3'b110, 0, 1, 1, mk(1, C_00, S_0, 3'b000, 1)));
    s.push_back(sp(1, 3'b100, 3'b111, 1, 1, mk(0, C_F1, S_F, 3'b000, 1)));
    s.push_back(sp(1, 3'b100, 3'b111, 1, 1, mk(1, C_00, S_0, 3'b000, 2)));
    s.push_back(sp(1, 3'b100, 3'b111, 1, 1, mk(2, C_RD, S_0, 3'b000, 2)));
    s.push_back(sp(1, 3'b100, 3'b111, 1, 1, mk(7, C_00, S_A, 3'b000, 2)));
    s.push_back(sp(1, 3'b100, 3'b111, 1, 0, mk(0, C_F0, S_F, 3'b000, 2)));
    foreach (s[i]) begin
      sb.push_back(s[i].e); drive(s[i]);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL nop step%0d got st=%0d ctl=%b sel=%b opc=%b cnt=%0d need st=%0d ctl=%b sel=%b opc=%b cnt=%0d",
                 i, o.st, o.ctl, o.sel, o.opc, o.cnt, e.st, e.ctl, e.sel, e.opc, e.cnt);
      end
    end
  endtask

  // 15 back-to-back jumps bring the 4-bit counter to 15; the next fetch wraps
  task automatic test_back_to_back_wrap();
    step_t s[$]; exp_t e, o;
    logic [3:0] k1;
    s.push_back(sp(0, 3'b010, 0, 0, 0, mk(0, C_00, S_F, 3'b000, 2)));
    for (int k = 0; k < 15; k++) begin
      k1 = 4'(k + 1);
      s.push_back(sp(1, 3'b010, 0, 0, 1, mk(0, C_F1, S_F, 3'b000, 4'(k))));
      s.push_back(sp(1, 3'b010, 0, 0, 1, mk(1, C_00, S_0, 3'b000, k1)));
      s.push_back(sp(1, 3'b010, 0, 0, 1, mk(5, C_JP, S_0, 3'b000, k1)));
    end
    s.push_back(sp(1, 3'b101, 0, 0, 1, mk(0, C_F1, S_F, 3'b000, 15)));
    s.push_back(sp(1, 3'b101, 0, 0, 1, mk(1, C_00, S_0, 3'b000, 0)));
    s.push_back(sp(1, 3'b101, 0, 0, 0, mk(0, C_F0, S_F, 3'b000, 0)));
    foreach (s[i]) begin
      sb.push_back(s[i].e); drive(s[i]);
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jump_wrap step%0d got st=%0d ctl=%b sel=%b opc=%b cnt=%0d need st=%0d ctl=%b sel=%b opc=%b cnt=%0d",
                 i, o.st, o.ctl, o.sel, o.opc, o.cnt, e.st, e.ctl, e.sel, e.opc, e.cnt);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; opcode = 3'b000; func = 3'b000; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    armed = 1'b1;
    test_reset();
    test_load();
    test_alu_wait();
    test_branch();
    test_store_reset();
    test_nop();
    test_back_to_back_wrap();
    armed = 1'b0;
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
